// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: buffers samples pushed by an upstream writer and
// releases one per programmed sample period as a single-cycle strobe.
// Optional build macro: STREAM_ZERO_FILL_EN (insert silence on underrun).
module audio_sample_streamer #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [DIV_W-1:0]              div,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [DATA_W-1:0]             audio_sample,
   output logic                          sample_valid,
   output logic                          underrun,
   input  logic                          clear_underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_TWO  = {{(DIV_W-2){1'b0}}, 2'b10};
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
   localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   // Divider values below 2 cannot form a meaningful period; clamp them.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d < DIV_TWO) ? DIV_TWO : d;
   endfunction

   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [LVL_W-1:0]  level_r;
   logic [DIV_W-1:0]  cnt_r;
   logic              in_ready_r;
   logic [DATA_W-1:0] audio_sample_r;
   logic              sample_valid_r;
   logic              underrun_r;

   logic [DIV_W-1:0]  eff_div_s;
   logic [DIV_W-1:0]  cnt_cur_s;
   logic              tick_s;
   logic              empty_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic [LVL_W-1:0]  level_nxt_s;

   // Tick, handshake and next-level decode. A counter value of zero only
   // exists right after reset and stands for "freshly loaded with eff div",
   // which avoids an asynchronous load of a non-constant value.
   always_comb begin
      eff_div_s   = eff_div(div);
      cnt_cur_s   = (cnt_r == DIV_ZERO) ? eff_div_s : cnt_r;
      tick_s      = enable && (cnt_cur_s == DIV_ONE);
      empty_s     = (level_r == LVL_ZERO);
      full_s      = (level_r == FULL_LVL);
      push_s      = in_valid && !full_s;
      pop_s       = tick_s && !empty_s;
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Sample-period counter: held at the effective divider while disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= DIV_ZERO;
      end else if (!enable) begin
         cnt_r <= eff_div_s;
      end else if (tick_s) begin
         cnt_r <= eff_div_s;
      end else begin
         cnt_r <= cnt_cur_s - DIV_ONE;
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // FIFO pointers, level and registered ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         level_r    <= LVL_ZERO;
         in_ready_r <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r    <= level_nxt_s;
         in_ready_r <= (level_nxt_s != FULL_LVL);
      end
   end

   // Output sample, strobe and sticky underrun (a new underrun beats clear).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         audio_sample_r <= {DATA_W{1'b0}};
         sample_valid_r <= 1'b0;
         underrun_r     <= 1'b0;
      end else begin
         if (pop_s) begin
            audio_sample_r <= mem_r[rd_ptr_r];
            sample_valid_r <= 1'b1;
         end else if (tick_s) begin
`ifdef STREAM_ZERO_FILL_EN
            audio_sample_r <= {DATA_W{1'b0}};
            sample_valid_r <= 1'b1;
`else
            audio_sample_r <= audio_sample_r;
            sample_valid_r <= 1'b0;
`endif
         end else begin
            audio_sample_r <= audio_sample_r;
            sample_valid_r <= 1'b0;
         end
         if (tick_s && empty_s) begin
            underrun_r <= 1'b1;
         end else if (clear_underrun) begin
            underrun_r <= 1'b0;
         end else begin
            underrun_r <= underrun_r;
         end
      end
   end

   assign in_ready     = in_ready_r;
   assign audio_sample = audio_sample_r;
   assign sample_valid = sample_valid_r;
   assign underrun     = underrun_r;
   assign fifo_level   = level_r;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Scoreboard bench for audio_sample_streamer: directed stimulus pushes the
// expected output samples into a queue, a negedge monitor pops and compares
// on every strobe and also checks strobe spacing and width.
`timescale 1ns/1ps
module tb_audio_sample_streamer;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] div;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] audio_sample;
   logic        sample_valid;
   logic        underrun;
   logic        clear_underrun;
   logic [4:0]  fifo_level;

   int          total;
   int          bad;
   int          cyc;
   int          last_cyc;
   int          exp_gap;
   bit          gap_en;
   logic        prev_sv;
   logic [15:0] exp_q [$];

   audio_sample_streamer #(.DATA_W(16), .FIFO_DEPTH(16), .DIV_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .div            (div),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .audio_sample   (audio_sample),
      .sample_valid   (sample_valid),
      .underrun       (underrun),
      .clear_underrun (clear_underrun),
      .fifo_level     (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter used for strobe spacing
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (sample_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            chk("strobe_data", {16'd0, audio_sample}, {16'd0, exp_q.pop_front()});
         end
         if (gap_en) chk("strobe_gap", cyc - last_cyc, exp_gap);
         chk("strobe_width", {31'd0, prev_sv}, 32'd0);
         last_cyc = cyc;
      end
      prev_sv = sample_valid;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      in_data  = v;
      in_valid = 1'b1;
      cycles(1);
      in_valid = 1'b0;
   endtask

   // wait until every expected strobe has been seen, then stop streaming
   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycles(1);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
      enable = 1'b0;
      gap_en = 1'b0;
   endtask

   // silence expected only when zero fill is built in
   task automatic exp_fill(input int n);
`ifdef STREAM_ZERO_FILL_EN
      repeat (n) exp_q.push_back(16'h0000);
`else
      if (n < 0) exp_q.push_back(16'h0000);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      logic [15:0] v;
      int n;
      total = 0; bad = 0; cyc = 0; last_cyc = 0; exp_gap = 0; gap_en = 1'b0; prev_sv = 1'b0;
      rst = 1'b0; enable = 1'b0; div = 16'd2; in_data = 16'd0; in_valid = 1'b0;
      clear_underrun = 1'b0;

      // reset state
      cycles(2);
      chk("rst_level", {27'd0, fifo_level}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_underrun", {31'd0, underrun}, 32'd0);
      chk("rst_sample", {16'd0, audio_sample}, 32'd0);
      rst = 1'b1;
      cycles(1);

      // rate: prefilled FIFO, strobes 2268 cycles apart
      div = 16'd2268;
      push(16'd10);    exp_q.push_back(16'd10);
      push(-16'sd10);  exp_q.push_back(16'hFFF6);
      push(16'd32767); exp_q.push_back(16'h7FFF);
      push(16'h8000);  exp_q.push_back(16'h8000);
      chk("prefill_level", {27'd0, fifo_level}, 32'd4);
      last_cyc = cyc; exp_gap = 2268; gap_en = 1'b1;
      enable = 1'b1;
      drain(4 * 2268 + 20);
      chk("rate_no_underrun", {31'd0, underrun}, 32'd0);

      // reset mid-stream with 5 buffered entries
      for (int i = 0; i < 5; i++) push(16'(i + 50));
      enable = 1'b1;
      cycles(3);
      chk("mid_level", {27'd0, fifo_level}, 32'd5);
      rst = 1'b0;
      #1;
      chk("mid_rst_level", {27'd0, fifo_level}, 32'd0);
      chk("mid_rst_sample", {16'd0, audio_sample}, 32'd0);
      chk("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
      div = 16'd5;
      exp_fill(1);
      cycles(1);
      rst = 1'b1;
      cycles(4);
      chk("post_rst_no_underrun_yet", {31'd0, underrun}, 32'd0);
      cycles(1);
      chk("post_rst_underrun", {31'd0, underrun}, 32'd1);
      enable = 1'b0;
      clear_underrun = 1'b1;
      cycles(1);
      clear_underrun = 1'b0;
      chk("clear_underrun", {31'd0, underrun}, 32'd0);

      // full / backpressure
      div = 16'd4;
      for (int i = 0; i < 16; i++) begin
         v = 16'(16'h1000 + i * 3);
         push(v);
         exp_q.push_back(v);
      end
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      chk("full_level", {27'd0, fifo_level}, 32'd16);
      in_data = 16'd999; in_valid = 1'b1;
      cycles(3);
      chk("full_no_17th", {27'd0, fifo_level}, 32'd16);
      in_valid = 1'b0;
      last_cyc = cyc; exp_gap = 4; gap_en = 1'b1;
      enable = 1'b1;
      cycles(3);
      chk("ready_before_pop", {31'd0, in_ready}, 32'd0);
      cycles(1);
      chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
      chk("level_after_pop", {27'd0, fifo_level}, 32'd15);
      drain(16 * 4 + 20);

      // wrap-around: div=2, continuous push of 40 distinct values
      div = 16'd2;
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         v = 16'(300 + i * 7);
         in_data = v; in_valid = 1'b1;
         n = 0;
         ok = 1'b0;
         while (!ok && n < 100) begin
            ok = in_ready;
            cycles(1);
            n++;
         end
         chk("wrap_push_timeout", {31'd0, ok}, 32'd1);
         exp_q.push_back(v);
      end
      in_valid = 1'b0;
      drain(40 * 2 + 40);
      chk("wrap_no_underrun", {31'd0, underrun}, 32'd0);

      // underrun: one sample, then empty ticks
      div = 16'd5;
      push(16'd1234);
      exp_q.push_back(16'd1234);
      exp_fill(2);
      last_cyc = cyc; exp_gap = 5; gap_en = 1'b1;
      enable = 1'b1;
      cycles(9);
      chk("ur_not_yet", {31'd0, underrun}, 32'd0);
      cycles(1);
      chk("ur_set", {31'd0, underrun}, 32'd1);
`ifdef STREAM_ZERO_FILL_EN
      chk("ur_sample", {16'd0, audio_sample}, 32'd0);
      chk("ur_valid", {31'd0, sample_valid}, 32'd1);
`else
      chk("ur_sample_held", {16'd0, audio_sample}, 32'd1234);
      chk("ur_no_strobe", {31'd0, sample_valid}, 32'd0);
`endif
      cycles(4);
      clear_underrun = 1'b1;
      cycles(1);
      chk("ur_set_wins", {31'd0, underrun}, 32'd1);
      cycles(1);
      chk("ur_cleared", {31'd0, underrun}, 32'd0);
      clear_underrun = 1'b0;
      enable = 1'b0;
      gap_en = 1'b0;
      cycles(2);

`ifdef STREAM_ZERO_FILL_EN
      // zero fill: silence every 3 cycles from an empty FIFO
      div = 16'd3;
      exp_fill(3);
      last_cyc = cyc; exp_gap = 3; gap_en = 1'b1;
      enable = 1'b1;
      drain(3 * 3 + 10);
      chk("zf_underrun", {31'd0, underrun}, 32'd1);
`endif

      cycles(5);
      chk("final_queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
